// File: rtl/cordic_sincos_hs.sv
// Iterative CORDIC sine/cosine engine with valid/ready handshakes.
// An accepted angle is folded into one quadrant, rotated ITER times
// (one micro-rotation per clock) and mapped back to the full circle.
// Angles at or beyond 360 degrees are flagged with err and yield zero.
module cordic_sincos_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BIT   = 16,
    parameter int ITER       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic        [DATA_WIDTH-1:0] phase,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] sin,
    output logic signed [DATA_WIDTH-1:0] cos,
    output logic                         err
);

    // Internal x/y/z carry two guard bits above the output width.
    localparam int ZW  = DATA_WIDTH + 2;
    // Counter width covers ITER up to 24; the table is padded to 2^IW
    // entries so any counter value indexes inside it.
    localparam int IW  = 5;
    localparam int TAB = 1 << IW;
    localparam real PI = 3.14159265358979323846;

    // Elaboration-time parameter checks.
    if (ITER < 1 || ITER > 24) begin : g_bad_iter
        $error("cordic_sincos_hs: ITER must lie in 1..24");
    end
    if (FRAC_BIT + 10 > DATA_WIDTH - 1) begin : g_bad_frac
        $error("cordic_sincos_hs: FRAC_BIT+10 must not exceed DATA_WIDTH-1");
    end

    // CORDIC gain compensation: product of 1/sqrt(1+2^-2i) over all iterations.
    function automatic real gain_f();
        real k;
        k = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
        end
        return k;
    endfunction

    localparam real               X0_R = gain_f() * (2.0 ** FRAC_BIT);
    localparam logic signed [ZW-1:0] X0 = ZW'(longint'(X0_R));

    // Quadrant boundaries in degrees * 2^FRAC_BIT.
    localparam logic [DATA_WIDTH-1:0] P90  = DATA_WIDTH'(90) << FRAC_BIT;
    localparam logic [DATA_WIDTH-1:0] P180 = P90 + P90;
    localparam logic [DATA_WIDTH-1:0] P270 = P180 + P90;
    localparam logic [DATA_WIDTH-1:0] P360 = P270 + P90;

    // Arctangent table in degrees * 2^FRAC_BIT, rounded at elaboration.
    logic signed [ZW-1:0] atan_tab [TAB];
    for (genvar g = 0; g < TAB; g++) begin : g_atan
        localparam real ANG = $atan(2.0 ** (-g)) * 180.0 / PI * (2.0 ** FRAC_BIT);
        if (g < ITER) begin : g_used
            assign atan_tab[g] = ZW'(longint'(ANG));
        end else begin : g_pad
            assign atan_tab[g] = '0;
        end
    end

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t                      state_q;
    logic signed [ZW-1:0]        x_q, y_q, z_q;
    logic signed [ZW-1:0]        x_d, y_d, z_d;
    logic        [IW-1:0]        iter_q;
    logic        [1:0]           quad_q;
    logic signed [DATA_WIDTH-1:0] sin_q, cos_q;
    logic                        err_q;

    logic        [1:0]           quad_cap;
    logic        [DATA_WIDTH-1:0] quad_base;
    logic                        out_of_range;
    logic signed [ZW-1:0]        z_cap;
    logic signed [ZW-1:0]        sin_full, cos_full;

    // Clamp a wide signed value into the signed output range.
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ZW-1:0] v);
        logic [2:0] top;
        top = v[ZW-1:DATA_WIDTH-1];
        if (top == 3'b000 || top == 3'b111) begin
            return v[DATA_WIDTH-1:0];
        end else if (v[ZW-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    // Quadrant fold of the incoming phase by a compare chain.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_of_range = 1'b0;
        quad_cap     = 2'd0;
        quad_base    = '0;
        if (phase >= P360) begin
            out_of_range = 1'b1;
        end else if (phase >= P270) begin
            quad_cap  = 2'd3;
            quad_base = P270;
        end else if (phase >= P180) begin
            quad_cap  = 2'd2;
            quad_base = P180;
        end else if (phase >= P90) begin
            quad_cap  = 2'd1;
            quad_base = P90;
        end
        z_cap = $signed(ZW'(phase - quad_base));
    end

    // One micro-rotation plus the quadrant map of its result.
    always_comb begin
        logic signed [ZW-1:0] x_sh, y_sh;
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        if (!z_q[ZW-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_tab[iter_q];
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_tab[iter_q];
        end
        case (quad_q)
            2'd0:    begin cos_full =  x_d; sin_full =  y_d; end
            2'd1:    begin cos_full = -y_d; sin_full =  x_d; end
            2'd2:    begin cos_full = -x_d; sin_full = -y_d; end
            default: begin cos_full =  y_d; sin_full = -x_d; end
        endcase
    end

    // Control FSM with registered datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            quad_q  <= 2'd0;
            sin_q   <= '0;
            cos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        err_q   <= out_of_range;
                        state_q <= ROT;
                        if (out_of_range) begin
                            // Zero vectors rotate to zero: one pass through ROT
                            // produces sin = cos = 0 one cycle later.
                            x_q    <= '0;
                            y_q    <= '0;
                            z_q    <= '0;
                            quad_q <= 2'd0;
                            iter_q <= IW'(ITER - 1);
                        end else begin
                            x_q    <= X0;
                            y_q    <= '0;
                            z_q    <= z_cap;
                            quad_q <= quad_cap;
                            iter_q <= '0;
                        end
                    end
                end
                ROT: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == IW'(ITER - 1)) begin
                        sin_q   <= sat(sin_full);
                        cos_q   <= sat(cos_full);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sin       = sin_q;
    assign cos       = cos_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cordic_sincos_hs.sv
// Scoreboard bench for cordic_sincos_hs: accepted phases push a
// real-math expectation; a monitor checks each presented result.
module tb_cordic_sincos_hs;

    localparam int          DW   = 32;
    localparam int          FB   = 16;
    localparam int          IT   = 16;
    localparam int          TOL  = IT + 2;
    localparam logic [31:0] D1   = 32'd65536;
    localparam logic [31:0] P360 = 32'd23592960;
    localparam real         PI   = 3.14159265358979323846;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic        [DW-1:0] phase;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] sin;
    logic signed [DW-1:0] cos;
    logic                 err;

    cordic_sincos_hs #(.DATA_WIDTH(DW), .FRAC_BIT(FB), .ITER(IT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .phase    (phase),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sin      (sin),
        .cos      (cos),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ph;
        logic        exp_err;
        int          exp_sin;
        int          exp_cos;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   bp_mode  = 1'b0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit near(input int a, input int b);
        return (a - b <= TOL) && (b - a <= TOL);
    endfunction

    // Reference: plain real trigonometry on the angle in degrees.
    function automatic exp_t model(input logic [31:0] ph, input int acc);
        exp_t e;
        real  rad;
        e.ph      = ph;
        e.acc_cyc = acc;
        if (ph >= P360) begin
            e.exp_err = 1'b1;
            e.exp_sin = 0;
            e.exp_cos = 0;
        end else begin
            rad       = (real'(ph) / 65536.0) * PI / 180.0;
            e.exp_err = 1'b0;
            e.exp_sin = int'($sin(rad) * 65536.0);
            e.exp_cos = int'($cos(rad) * 65536.0);
        end
        return e;
    endfunction

    // Input monitor: every accepted phase pushes its expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready) sb.push_back(model(phase, cyc));
    end

    // Output monitor: latency on rise, stability under back-pressure, value on handshake.
    initial begin
        bit                   prev_ov;
        bit                   snap_v;
        logic signed [DW-1:0] s_sin, s_cos;
        logic                 s_err;
        exp_t                 e;
        int                   lat, req;
        prev_ov = 1'b0;
        snap_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                snap_v  = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 1'b0, 1, 0);
                    end else begin
                        lat = cyc - sb[0].acc_cyc - 1;
                        req = sb[0].exp_err ? 1 : IT;
                        check("latency", lat == req, lat, req);
                    end
                end
                if (out_valid) begin
                    check("in_ready_low_in_done", in_ready == 1'b0, in_ready, 0);
                    if (snap_v) begin
                        check("hold_sin", sin == s_sin, sin, s_sin);
                        check("hold_cos", cos == s_cos, cos, s_cos);
                        check("hold_err", err == s_err, err, s_err);
                    end
                end
                if (out_valid && out_ready) begin
                    snap_v = 1'b0;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("err", err == e.exp_err, err, e.exp_err);
                        if (e.exp_err) begin
                            check("sin_err_zero", sin == 0, sin, 0);
                            check("cos_err_zero", cos == 0, cos, 0);
                        end else begin
                            check("sin", near(int'(sin), e.exp_sin), sin, e.exp_sin);
                            check("cos", near(int'(cos), e.exp_cos), cos, e.exp_cos);
                        end
                    end
                end else if (out_valid) begin
                    snap_v = 1'b1;
                    s_sin  = sin;
                    s_cos  = cos;
                    s_err  = err;
                end else begin
                    snap_v = 1'b0;
                end
                prev_ov = out_valid;
            end
        end
    end

    // Random back-pressure generator, active only when bp_mode is set.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] p);
        int n;
        n        = 0;
        phase    = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1'b0, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 1'b0, sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] dir [10];

    initial begin
        int n;
        dir = '{32'd0, 32'd1966080, 32'd8847360, 32'd17694720, 32'd5898240,
                32'd23592960, 32'd1966080, 32'd11796480, 32'd23592959, 32'hFFFF_FFFF};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        phase     = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_sin", sin == 0, sin, 0);
        check("rst_cos", cos == 0, cos, 0);
        check("rst_err", err == 1'b0, err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed angles: axes, 30/135 degrees, range edge and out-of-range.
        foreach (dir[i]) send(dir[i]);
        wait_drain();

        // Back-pressure: hold out_ready low in DONE while a new phase waits.
        out_ready = 1'b0;
        send(32'd1966080);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", out_valid == 1'b1, out_valid, 1);
        #1;
        phase    = 32'd8847360;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready == 1'b0, in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_done", in_ready == 1'b0, in_ready, 0);
        @(negedge clk);
        check("bp_ready_after_handshake", in_ready == 1'b1, in_ready, 1);
        send(32'd8847360);
        wait_drain();

        // Asynchronous reset in the middle of the rotation.
        send(32'd1966080);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrot_out_valid", out_valid == 1'b0, out_valid, 0);
        check("midrot_in_ready", in_ready == 1'b1, in_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'd0);
        wait_drain();

        // Randomized angles with random back-pressure.
        bp_mode = 1'b1;
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) send(P360 + $urandom_range(0, 1000000));
            else send($urandom_range(0, P360 - 1));
        end
        wait_drain();
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
